// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes and field positions
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    typedef enum logic [4:0] {
        EXCCODE_INT  = 5'd0,
        EXCCODE_ADEL = 5'd4,
        EXCCODE_ADES = 5'd5,
        EXCCODE_SYS  = 5'd8,
        EXCCODE_RI   = 5'd10,
        EXCCODE_OV   = 5'd12,
        EXCCODE_TR   = 5'd13
    } exc_code_e;

    typedef struct packed {
        logic      valid;
        exc_code_e code;
    } exc_dec_t;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;

    // IV, WP and the two software IP bits are the only MTC0-writable Cause bits
    localparam logic [31:0] CAUSE_SW_MASK = 32'h00C0_0300;

    function automatic exc_dec_t decode_except(input logic [31:0] t, input logic badv_en);
        exc_dec_t d;
        d.valid = 1'b1;
        d.code  = EXCCODE_INT;
        case (t)
            EXC_INT:  d.code = EXCCODE_INT;
            EXC_SYS:  d.code = EXCCODE_SYS;
            EXC_RI:   d.code = EXCCODE_RI;
            EXC_OV:   d.code = EXCCODE_OV;
            EXC_TR:   d.code = EXCCODE_TR;
            EXC_ADEL: begin d.valid = badv_en; d.code = EXCCODE_ADEL; end
            EXC_ADES: begin d.valid = badv_en; d.code = EXCCODE_ADES; end
            default:  d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// rtl/cp0_int_sync.sv - multi-flop synchroniser for hardware interrupt levels
module cp0_int_sync #(
    parameter int W      = 6,
    parameter int STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_sync
            logic [STAGES-1:0][W-1:0] r_sync;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= i_d;
                    for (int i = 1; i < STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign o_q = r_sync[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/cp0_regfile_p.sv
// rtl/cp0_regfile_p.sv - CP0 register file with timer, interrupt sync and MTC0 forwarding
// Optional BadVAddr register and AdEL/AdES codes when CP0_BADVADDR_EN is defined.
module cp0_regfile_p
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT  = 6,
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMER_DIV   = 1,
    parameter logic [31:0] STATUS_RST  = 32'h1000_0000,
    parameter logic [31:0] PRID_VAL    = 32'h0087_0102,
    parameter logic [31:0] CONFIG_VAL  = 32'h0000_8000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            raddr_i,
    input  logic [31:0]           except_type_i,
    input  logic [31:0]           current_inst_addr_i,
    input  logic                  is_in_delayslot_i,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0]           bad_addr_i,
    output logic [31:0]           badvaddr_o,
`endif
    output logic [31:0]           data_o,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           config_o,
    output logic [31:0]           prid_o,
    output logic                  timer_int_o,
    output logic                  int_pending_o
);

`ifdef CP0_BADVADDR_EN
    localparam logic BADV_EN = 1'b1;
`else
    localparam logic BADV_EN = 1'b0;
`endif
    localparam logic [7:0] PRESC_LAST = 8'(TIMER_DIV - 1);

    logic [31:0] r_count, r_compare, r_status, r_cause, r_epc;
    logic [7:0]  r_presc;
    logic        r_timer, r_int_pending;

    logic [NUM_HW_INT-1:0] w_int_sync;
    logic [5:0]            w_hw_ip;
    exc_dec_t              w_exc;
    logic                  w_eret, w_nested;
    logic [31:0]           w_status_n, w_cause_n, w_epc_n, w_rd;

    cp0_int_sync #(
        .W      (NUM_HW_INT),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     (int_i),
        .o_q     (w_int_sync)
    );

    assign w_hw_ip  = 6'(w_int_sync) | {r_timer, 5'b0};
    assign w_exc    = decode_except(except_type_i, BADV_EN);
    assign w_eret   = (except_type_i == EXC_ERET);
    assign w_nested = r_status[STATUS_EXL];

    // MTC0 is applied first, then the committed exception overrides its own fields
    always_comb begin
        w_status_n = r_status;
        if (we_i && waddr_i == CP0_STATUS) w_status_n = wdata_i;
        if (w_exc.valid)  w_status_n[STATUS_EXL] = 1'b1;
        else if (w_eret)  w_status_n[STATUS_EXL] = 1'b0;

        w_cause_n        = r_cause;
        w_cause_n[15:10] = w_hw_ip;
        if (we_i && waddr_i == CP0_CAUSE)
            w_cause_n = (w_cause_n & ~CAUSE_SW_MASK) | (wdata_i & CAUSE_SW_MASK);
        if (w_exc.valid) begin
            w_cause_n[6:2] = w_exc.code;
            if (!w_nested) w_cause_n[CAUSE_BD] = is_in_delayslot_i;
        end

        w_epc_n = r_epc;
        if (we_i && waddr_i == CP0_EPC) w_epc_n = wdata_i;
        if (w_exc.valid && !w_nested)
            w_epc_n = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status      <= STATUS_RST;
            r_cause       <= '0;
            r_epc         <= '0;
            r_int_pending <= 1'b0;
        end else begin
            r_status      <= w_status_n;
            r_cause       <= w_cause_n;
            r_epc         <= w_epc_n;
            r_int_pending <= |(r_cause[15:8] & r_status[15:8]) & r_status[STATUS_IE]
                             & ~r_status[STATUS_EXL];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_presc <= '0;
        end else if (we_i && waddr_i == CP0_COUNT) begin
            r_count <= wdata_i;
            r_presc <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_count <= r_count + 32'd1;
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_compare <= '0;
            r_timer   <= 1'b0;
        end else if (we_i && waddr_i == CP0_COMPARE) begin
            r_compare <= wdata_i;
            r_timer   <= 1'b0;
        end else if (r_count == r_compare && r_compare != 32'd0) begin
            r_timer   <= 1'b1;
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] r_badvaddr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_badvaddr <= '0;
        end else if (w_exc.valid && (w_exc.code == EXCCODE_ADEL || w_exc.code == EXCCODE_ADES)) begin
            r_badvaddr <= bad_addr_i;
        end
    end

    assign badvaddr_o = r_badvaddr;
`endif

    always_comb begin
        w_rd = '0;
        case (raddr_i)
            CP0_COUNT:    w_rd = r_count;
            CP0_COMPARE:  w_rd = r_compare;
            CP0_STATUS:   w_rd = r_status;
            CP0_CAUSE:    w_rd = r_cause;
            CP0_EPC:      w_rd = r_epc;
            CP0_PRID:     w_rd = PRID_VAL;
            CP0_CONFIG:   w_rd = CONFIG_VAL;
`ifdef CP0_BADVADDR_EN
            CP0_BADVADDR: w_rd = r_badvaddr;
`endif
            default:      w_rd = '0;
        endcase
        // Read-only and unknown registers keep their normal read value when forwarded
        if (we_i && waddr_i == raddr_i) begin
            case (waddr_i)
                CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_EPC: w_rd = wdata_i;
                CP0_CAUSE: w_rd = (r_cause & ~CAUSE_SW_MASK) | (wdata_i & CAUSE_SW_MASK);
                default:   ;
            endcase
        end
    end

    assign data_o        = w_rd;
    assign count_o       = r_count;
    assign compare_o     = r_compare;
    assign status_o      = r_status;
    assign cause_o       = r_cause;
    assign epc_o         = r_epc;
    assign config_o      = CONFIG_VAL;
    assign prid_o        = PRID_VAL;
    assign timer_int_o   = r_timer;
    assign int_pending_o = r_int_pending;

endmodule
